// File: rtl/cpu_commit_checker.sv
// Commit checker: compares CPU register-writeback commits, in program order,
// against a preloaded expected-result table, with pass/fail counts and stall timeout.
module cpu_commit_checker #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int REG_AW    = 4,
  parameter int TO_CYCLES = 64,
  localparam int AW       = $clog2(DEPTH),
  localparam int EW       = WIDTH + REG_AW + 5
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              exp_we,
  input  logic [AW-1:0]     exp_addr,
  input  logic [EW-1:0]     exp_data,
  input  logic [AW:0]       exp_count,
  input  logic              start,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              wb_s,
  input  logic [3:0]        nzcv,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [AW:0]       commit_cnt,
  output logic [AW:0]       fail_cnt,
  output logic [7:0]        extra_cnt,
  output logic [AW-1:0]     first_fail_idx
);

  localparam int IW = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       commit_q, commit_d;
  logic [AW:0]       fail_q, fail_d;
  logic [AW:0]       target_q, target_d;
  logic [7:0]        extra_q, extra_d;
  logic [AW-1:0]     ffi_q, ffi_d;
  logic [IW-1:0]     idle_q, idle_d;

  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     entry;
  logic              match;

  // Table is not reset so a rerun after Rst still sees the loaded entries.
  always_ff @(posedge clk) begin
    if (exp_we && state_q != S_RUN) begin
      mem[exp_addr] <= exp_data;
    end
  end

  assign entry = mem[commit_q[AW-1:0]];
  assign match = (wb_reg == entry[WIDTH +: REG_AW]) &&
                 (wb_data == entry[WIDTH-1:0]) &&
                 (!entry[EW-1] || (wb_s && nzcv == entry[WIDTH+REG_AW +: 4]));

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      commit_q <= '0;
      fail_q   <= '0;
      target_q <= '0;
      extra_q  <= '0;
      ffi_q    <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      commit_q <= commit_d;
      fail_q   <= fail_d;
      target_q <= target_d;
      extra_q  <= extra_d;
      ffi_q    <= ffi_d;
      idle_q   <= idle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    commit_d = commit_q;
    fail_d   = fail_q;
    target_d = target_q;
    extra_d  = extra_q;
    ffi_d    = ffi_q;
    idle_d   = idle_q;
    case (state_q)
      S_RUN: begin
        if (wb_valid) begin
          idle_d   = '0;
          commit_d = commit_q + 1'b1;
          if (!match) begin
            fail_d = fail_q + 1'b1;
            if (fail_q == '0) ffi_d = commit_q[AW-1:0];
          end
          if (commit_d == target_q) state_d = S_DONE;
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_d == IW'(TO_CYCLES)) state_d = S_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          commit_d = '0;
          fail_d   = '0;
          extra_d  = '0;
          ffi_d    = '0;
          idle_d   = '0;
          target_d = exp_count;
          state_d  = (exp_count == '0) ? S_DONE : S_RUN;
        end else if (state_q == S_DONE && wb_valid && extra_q != 8'hFF) begin
          extra_d = extra_q + 8'd1;
        end
      end
    endcase
  end

  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign timeout        = (state_q == S_TIMEOUT);
  assign pass           = done && (fail_q == '0) && (extra_q == '0);
  assign commit_cnt     = commit_q;
  assign fail_cnt       = fail_q;
  assign extra_cnt      = extra_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_cpu_commit_checker.sv
// Bench for cpu_commit_checker: queue-based reference model checked every cycle,
// plus literal expectations after each directed scenario.
module tb_cpu_commit_checker;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int RA = 4;
  localparam int TO = 64;
  localparam int EW = W + RA + 5;

  logic          clk = 1'b0;
  logic          Rst = 1'b1;
  logic          exp_we = 1'b0;
  logic [3:0]    exp_addr = '0;
  logic [EW-1:0] exp_data = '0;
  logic [4:0]    exp_count = '0;
  logic          start = 1'b0;
  logic          wb_valid = 1'b0;
  logic [3:0]    wb_reg = '0;
  logic [31:0]   wb_data = '0;
  logic          wb_s = 1'b0;
  logic [3:0]    nzcv = '0;
  logic          busy, done, pass, timeout;
  logic [4:0]    commit_cnt, fail_cnt;
  logic [7:0]    extra_cnt;
  logic [3:0]    first_fail_idx;

  int vectors = 0;
  int miscompares = 0;

  cpu_commit_checker #(.WIDTH(W), .DEPTH(D), .REG_AW(RA), .TO_CYCLES(TO)) dut (
    .clk(clk), .Rst(Rst), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_count(exp_count), .start(start), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_data(wb_data), .wb_s(wb_s), .nzcv(nzcv), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .commit_cnt(commit_cnt), .fail_cnt(fail_cnt), .extra_cnt(extra_cnt),
    .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  // Reference model: a run is a queue of pending expected entries consumed by commits.
  logic [EW-1:0] tbl [D];
  logic [EW-1:0] pending [$];
  bit running = 0, finished = 0, stalled = 0;
  int checked = 0, fails = 0, extra = 0, firstIdx = 0, quiet = 0;

  always @(posedge clk or posedge Rst) begin
    if (Rst) begin
      pending.delete();
      running = 0; finished = 0; stalled = 0;
      checked = 0; fails = 0; extra = 0; firstIdx = 0; quiet = 0;
    end else begin
      if (exp_we && !running) tbl[exp_addr] = exp_data;
      if (running) begin
        if (wb_valid) begin
          logic [EW-1:0] e;
          bit ok;
          e = pending.pop_front();
          ok = (wb_reg == e[W +: RA]) && (wb_data == e[W-1:0]) &&
               (!e[EW-1] || (wb_s && nzcv == e[W+RA +: 4]));
          if (!ok) begin
            if (fails == 0) firstIdx = checked;
            fails++;
          end
          checked++;
          quiet = 0;
          if (pending.size() == 0) begin running = 0; finished = 1; end
        end else begin
          quiet++;
          if (quiet == TO) begin running = 0; stalled = 1; end
        end
      end else if (start) begin
        pending.delete();
        for (int i = 0; i < int'(exp_count); i++) pending.push_back(tbl[i]);
        checked = 0; fails = 0; extra = 0; firstIdx = 0; quiet = 0; stalled = 0;
        finished = (exp_count == 0);
        running  = !finished;
      end else if (finished && wb_valid && extra < 255) begin
        extra++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    checkOutput("busy", 32'(busy), 32'(running));
    checkOutput("done", 32'(done), 32'(finished));
    checkOutput("pass", 32'(pass), 32'(finished && fails == 0 && extra == 0));
    checkOutput("timeout", 32'(timeout), 32'(stalled));
    checkOutput("commit_cnt", 32'(commit_cnt), 32'(checked));
    checkOutput("fail_cnt", 32'(fail_cnt), 32'(fails));
    checkOutput("extra_cnt", 32'(extra_cnt), 32'(extra));
    checkOutput("first_fail_idx", 32'(first_fail_idx), 32'(firstIdx));
  end

  function automatic logic [EW-1:0] mkEntry(input logic chk, input logic [3:0] nz,
                                            input logic [3:0] rg, input logic [31:0] val);
    return {chk, nz, rg, val};
  endfunction

  task automatic loadEntry(input int addr, input logic [EW-1:0] data);
    @(negedge clk);
    exp_we = 1'b1; exp_addr = 4'(addr); exp_data = data;
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  task automatic startRun(input int count);
    @(negedge clk);
    start = 1'b1; exp_count = 5'(count);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] rg, input logic [31:0] val,
                               input logic s, input logic [3:0] nz);
    @(negedge clk);
    wb_valid = 1'b1; wb_reg = rg; wb_data = val; wb_s = s; nzcv = nz;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadBasicTable();
    loadEntry(0, mkEntry(1'b0, 4'b0000, 4'd1, 32'h5));
    loadEntry(1, mkEntry(1'b0, 4'b0000, 4'd2, 32'hA));
    loadEntry(2, mkEntry(1'b1, 4'b0000, 4'd3, 32'hF));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    Rst = 1'b0;

    // Three matching commits.
    loadBasicTable();
    startRun(3);
    applyStimulus(4'd1, 32'h5, 1'b0, 4'b0000);
    applyStimulus(4'd2, 32'hA, 1'b0, 4'b0000);
    applyStimulus(4'd3, 32'hF, 1'b1, 4'b0000);
    checkOutput("t1 done", 32'(done), 32'd1);
    checkOutput("t1 pass", 32'(pass), 32'd1);
    checkOutput("t1 commit_cnt", 32'(commit_cnt), 32'd3);
    checkOutput("t1 fail_cnt", 32'(fail_cnt), 32'd0);

    // Wrong data on the second commit.
    startRun(3);
    applyStimulus(4'd1, 32'h5, 1'b0, 4'b0000);
    applyStimulus(4'd2, 32'hB, 1'b0, 4'b0000);
    applyStimulus(4'd3, 32'hF, 1'b1, 4'b0000);
    checkOutput("t2 fail_cnt", 32'(fail_cnt), 32'd1);
    checkOutput("t2 first_fail_idx", 32'(first_fail_idx), 32'd1);
    checkOutput("t2 done", 32'(done), 32'd1);
    checkOutput("t2 pass", 32'(pass), 32'd0);

    // Flag check demanded but flags not updated by the instruction.
    loadEntry(0, mkEntry(1'b1, 4'b0100, 4'd4, 32'h7));
    startRun(1);
    applyStimulus(4'd4, 32'h7, 1'b0, 4'b0100);
    checkOutput("t3 fail_cnt", 32'(fail_cnt), 32'd1);
    checkOutput("t3 first_fail_idx", 32'(first_fail_idx), 32'd0);

    // Stall timeout, then a late commit that restarts the idle count.
    startRun(2);
    idleCycles(TO - 1);
    checkOutput("t4 timeout early", 32'(timeout), 32'd0);
    checkOutput("t4 busy early", 32'(busy), 32'd1);
    idleCycles(1);
    checkOutput("t4 timeout", 32'(timeout), 32'd1);
    checkOutput("t4 busy", 32'(busy), 32'd0);
    startRun(2);
    idleCycles(TO - 2);
    applyStimulus(4'd4, 32'h7, 1'b1, 4'b0100);
    idleCycles(TO - 1);
    checkOutput("t4 no timeout", 32'(timeout), 32'd0);
    idleCycles(1);
    checkOutput("t4 timeout again", 32'(timeout), 32'd1);

    // Full table, then extra commits with saturation.
    for (int i = 0; i < D; i++) loadEntry(i, mkEntry(1'b0, 4'b0000, 4'(i), 32'(i * 3 + 1)));
    startRun(D);
    for (int i = 0; i < D; i++) applyStimulus(4'(i), 32'(i * 3 + 1), 1'b0, 4'b0000);
    checkOutput("t5 done", 32'(done), 32'd1);
    checkOutput("t5 pass", 32'(pass), 32'd1);
    checkOutput("t5 commit_cnt", 32'(commit_cnt), 32'd16);
    applyStimulus(4'd0, 32'h0, 1'b0, 4'b0000);
    checkOutput("t5 extra_cnt", 32'(extra_cnt), 32'd1);
    checkOutput("t5 pass after extra", 32'(pass), 32'd0);
    for (int i = 0; i < 260; i++) applyStimulus(4'd0, 32'h0, 1'b0, 4'b0000);
    checkOutput("t5 extra_cnt sat", 32'(extra_cnt), 32'd255);

    // Reset mid-run, ignored write during RUN, empty run.
    loadBasicTable();
    startRun(3);
    applyStimulus(4'd1, 32'h5, 1'b0, 4'b0000);
    applyStimulus(4'd2, 32'hA, 1'b0, 4'b0000);
    Rst = 1'b1;
    #1;
    checkOutput("t6 rst busy", 32'(busy), 32'd0);
    checkOutput("t6 rst commit_cnt", 32'(commit_cnt), 32'd0);
    @(negedge clk);
    Rst = 1'b0;
    startRun(3);
    loadEntry(0, mkEntry(1'b0, 4'b0000, 4'd9, 32'hDEAD));
    applyStimulus(4'd1, 32'h5, 1'b0, 4'b0000);
    applyStimulus(4'd2, 32'hA, 1'b0, 4'b0000);
    applyStimulus(4'd3, 32'hF, 1'b1, 4'b0000);
    checkOutput("t6 rerun pass", 32'(pass), 32'd1);
    startRun(0);
    checkOutput("t6 empty done", 32'(done), 32'd1);
    checkOutput("t6 empty pass", 32'(pass), 32'd1);

    idleCycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
